result_unloader: RTL

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/result_unloader.sv | 93 +++++++++
 1 files changed

// File: rtl/result_unloader.sv
// Serialises a 32-bit core result into NBYTES bytes, MSB first, over a valid/ready byte port.
// A single frame is held at a time; results arriving while a frame is in flight are dropped and flagged.
module result_unloader #(
    parameter int NBYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] y,
    input  logic               y_valid,
    output logic               unload_busy,
    output logic [7:0]         out_pins,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overflow,
    output logic [7:0]         frame_cnt
);

    localparam int DATA_W = 32;
    // Captured bytes are left-aligned so the byte on the wire is always the top byte.
    localparam int PAD = 8 * (4 - NBYTES);
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift_p0, shift_nxt;
    logic [1:0]        idx_p0, idx_nxt;
    logic              vld_p0;
    logic              ovf_nxt;
    logic [7:0]        cnt_nxt;
    logic [DATA_W-1:0] y_u;

    assign y_u = y;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_p0;
        idx_nxt   = idx_p0;
        ovf_nxt   = overflow;
        cnt_nxt   = frame_cnt;
        case (state)
            S_IDLE: begin
                if (y_valid) begin
                    shift_nxt = y_u << PAD;
                    idx_nxt   = 2'd0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (y_valid) ovf_nxt = 1'b1;
                if (out_ready) begin
                    if (idx_p0 == LAST_IDX) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = frame_cnt + 8'd1;
                    end else begin
                        shift_nxt = shift_p0 << 8;
                        idx_nxt   = idx_p0 + 2'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: frame state, shift register and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_p0  <= '0;
            idx_p0    <= 2'd0;
            vld_p0    <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            shift_p0  <= shift_nxt;
            idx_p0    <= idx_nxt;
            vld_p0    <= (state_nxt == S_SEND);
            overflow  <= ovf_nxt;
            frame_cnt <= cnt_nxt;
        end
    end

    assign unload_busy = vld_p0;
    assign out_valid   = vld_p0;
    assign out_pins    = vld_p0 ? shift_p0[DATA_W-1 -: 8] : 8'd0;
    assign out_last    = vld_p0 && (idx_p0 == LAST_IDX);

endmodule
